// File: rtl/seq_alu.sv
// seq_alu: handshaked RV32 execution unit, base ops in one cycle, RV32M mul/div one bit per cycle.
// Optional build macro SEQ_ALU_FAST_MUL_EN swaps the iterative multiplier for a single-cycle one.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             a_sel,
  input  logic             b_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal_op,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLTU   = 5'h08;
  localparam logic [4:0] OP_SLT    = 5'h09;
  localparam logic [4:0] OP_PASSA  = 5'h0A;
  localparam logic [4:0] OP_PASSB  = 5'h0B;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d, illegal_q, illegal_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   a_s, b_s, mag_a_s, mag_b_s, base_res_s;
  logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [WIDTH:0]     mul_add_s, rem_sh_s;
  logic [WIDTH-1:0]   div_sub_s, step_hi_s, step_lo_s, quo_fix_s, rem_fix_s, final_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic               div_ge_s;

  function automatic logic [WIDTH-1:0] base_op(input logic [4:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (o)
      OP_ADD:   base_op = a + b;
      OP_SUB:   base_op = a - b;
      OP_AND:   base_op = a & b;
      OP_OR:    base_op = a | b;
      OP_XOR:   base_op = a ^ b;
      OP_SLL:   base_op = a << sh;
      OP_SRL:   base_op = a >> sh;
      OP_SRA:   base_op = WIDTH'($signed(a) >>> sh);
      OP_SLTU:  base_op = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:   base_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASSA: base_op = a;
      OP_PASSB: base_op = b;
      default:  base_op = '0;
    endcase
  endfunction

  // Operand selection, signedness and magnitudes of the incoming operation.
  always_comb begin
    a_s        = a_sel ? pc : rdata1;
    b_s        = b_sel ? imm : rdata2;
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: a_signed_s = 1'b1;
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s    = a_signed_s & a_s[WIDTH-1];
    b_neg_s    = b_signed_s & b_s[WIDTH-1];
    mag_a_s    = a_neg_s ? (~a_s + WIDTH'(1)) : a_s;
    mag_b_s    = b_neg_s ? (~b_s + WIDTH'(1)) : b_s;
    base_res_s = base_op(op, a_s, b_s);
  end

`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod_s;

  // Single-cycle product; a_neg_s/b_neg_s double as the sign-extension bits.
  always_comb begin
    fast_prod_s = {{WIDTH{a_neg_s}}, a_s} * {{WIDTH{b_neg_s}}, b_s};
  end
`endif

  // One shift-add (multiply) or restoring-subtract (divide) step, plus the sign fix-up.
  always_comb begin
    mul_add_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : {(WIDTH+1){1'b0}});
    rem_sh_s  = {hi_q, lo_q[WIDTH-1]};
    div_ge_s  = (rem_sh_s >= {1'b0, mc_q});
    div_sub_s = rem_sh_s[WIDTH-1:0] - mc_q;
    if (op_q[2] == 1'b0) begin
      step_hi_s = mul_add_s[WIDTH:1];
      step_lo_s = {mul_add_s[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi_s = div_ge_s ? div_sub_s : rem_sh_s[WIDTH-1:0];
      step_lo_s = {lo_q[WIDTH-2:0], div_ge_s};
    end
    prod_s     = {step_hi_s, step_lo_s};
    prod_fix_s = neg_q ? (~prod_s + (2*WIDTH)'(1)) : prod_s;
    quo_fix_s  = neg_q ? (~step_lo_s + WIDTH'(1)) : step_lo_s;
    rem_fix_s  = neg_q ? (~step_hi_s + WIDTH'(1)) : step_hi_s;
    case (op_q)
      OP_MUL:                       final_s = prod_fix_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_fix_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              final_s = quo_fix_s;
      OP_REM, OP_REMU:              final_s = rem_fix_s;
      default:                      final_s = '0;
    endcase
  end

  // Next-state logic: flush overrides every state, accept only from IDLE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      result_d  = '0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d      = op;
            cnt_d     = '0;
            illegal_d = 1'b0;
            state_d   = S_DONE;
            if ((op[4] == 1'b0) && (op[3:0] <= 4'hB)) begin
              result_d = base_res_s;
            end else if (op[4:2] == 3'b100) begin
`ifdef SEQ_ALU_FAST_MUL_EN
              result_d = (op == OP_MUL) ? fast_prod_s[WIDTH-1:0] : fast_prod_s[2*WIDTH-1:WIDTH];
`else
              hi_d    = '0;
              lo_d    = mag_b_s;
              mc_d    = mag_a_s;
              neg_d   = a_neg_s ^ b_neg_s;
              state_d = S_BUSY;
`endif
            end else if (op[4:2] == 3'b101) begin
              if (b_s == '0) begin
                result_d = op[1] ? a_s : '1;
              end else if (b_signed_s && (a_s == INT_MIN) && (b_s == '1)) begin
                result_d = op[1] ? '0 : INT_MIN;
              end else begin
                hi_d    = '0;
                lo_d    = mag_a_s;
                mc_d    = mag_b_s;
                neg_d   = op[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                state_d = S_BUSY;
              end
            end else begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          hi_d  = step_hi_s;
          lo_d  = step_lo_s;
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == LAST_CNT) begin
            result_d = final_s;
            state_d  = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mc_q      <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mc_q      <= mc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign result     = result_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (WIDTH=32) plus hand-written handshake/flush/reset sequences.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, a_sel, b_sel;
  logic         out_valid, out_ready, illegal_op, busy;
  logic [4:0]   op;
  logic [W-1:0] rdata1, rdata2, pc, imm, result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]   op;
    logic         a_sel;
    logic         b_sel;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic [W-1:0] pc;
    logic [W-1:0] imm;
    logic [W-1:0] exp;
    logic         exp_ill;
    int           kind;   // 0 single cycle, 1 multiply, 2 iterative divide
  } vec_t;

  vec_t vq[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rdata1(rdata1), .rdata2(rdata2), .pc(pc), .imm(imm), .a_sel(a_sel),
    .b_sel(b_sel), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [4:0] o, input logic as, input logic bs,
                              input logic [W-1:0] r1, input logic [W-1:0] r2,
                              input logic [W-1:0] p, input logic [W-1:0] im,
                              input logic [W-1:0] ex, input logic il, input int k);
    vec_t v;
    v.op = o; v.a_sel = as; v.b_sel = bs; v.r1 = r1; v.r2 = r2; v.pc = p; v.imm = im;
    v.exp = ex; v.exp_ill = il; v.kind = k;
    return v;
  endfunction

  function automatic int exp_lat(input int k);
    if (k == 0) return 1;
`ifdef SEQ_ALU_FAST_MUL_EN
    if (k == 1) return 1;
`endif
    return 33;
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drive(input vec_t v);
    op = v.op; a_sel = v.a_sel; b_sel = v.b_sel;
    rdata1 = v.r1; rdata2 = v.r2; pc = v.pc; imm = v.imm;
    in_valid = 1'b1;
  endtask

  // Wait for out_valid after the accept edge; returns edges counted from accept.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 80) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    wait_ready(name);
    drive(v);
    tick();
    in_valid = 1'b0;
    op = 5'($urandom); rdata1 = $urandom; rdata2 = $urandom; pc = $urandom; imm = $urandom;
    a_sel = 1'($urandom); b_sel = 1'($urandom);
    wait_valid(lat);
    check({name, "_latency"}, W'(lat), W'(exp_lat(v.kind)));
    check({name, "_result"}, result, v.exp);
    check({name, "_illegal"}, {31'd0, illegal_op}, {31'd0, v.exp_ill});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int   lat;
    int   seen;
    vec_t v;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 5'd0;
    a_sel = 1'b0; b_sel = 1'b0; rdata1 = '0; rdata2 = '0; pc = '0; imm = '0;
    repeat (3) tick();
    check("reset_flags", {27'd0, in_ready, out_valid, illegal_op, busy, 1'b0}, 32'h10);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {28'd0, in_ready, out_valid, illegal_op, busy}, 32'h8);

    vq.push_back(mk(5'h00, 1'b0, 1'b1, 32'd5, 32'h123, 32'h0, 32'hFFFFFFFF, 32'h00000004, 1'b0, 0));
    vq.push_back(mk(5'h01, 1'b0, 1'b0, 32'd3, 32'd5, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 0));
    vq.push_back(mk(5'h02, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'h0, 32'h0, 32'h00F01200, 1'b0, 0));
    vq.push_back(mk(5'h03, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'h0, 32'h0, 32'hFFF0FF34, 1'b0, 0));
    vq.push_back(mk(5'h04, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF0FF00, 32'h0, 32'h0, 32'hFF00ED34, 1'b0, 0));
    vq.push_back(mk(5'h05, 1'b0, 1'b0, 32'h00000001, 32'h00000024, 32'h0, 32'h0, 32'h00000010, 1'b0, 0));
    vq.push_back(mk(5'h06, 1'b0, 1'b0, 32'h80000000, 32'd31, 32'h0, 32'h0, 32'h00000001, 1'b0, 0));
    vq.push_back(mk(5'h07, 1'b0, 1'b0, 32'h80000000, 32'h00000021, 32'h0, 32'h0, 32'hC0000000, 1'b0, 0));
    vq.push_back(mk(5'h08, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'h00000000, 1'b0, 0));
    vq.push_back(mk(5'h09, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 32'h00000001, 1'b0, 0));
    vq.push_back(mk(5'h0A, 1'b1, 1'b0, 32'h55, 32'h66, 32'h1000, 32'h0, 32'h00001000, 1'b0, 0));
    vq.push_back(mk(5'h0B, 1'b0, 1'b0, 32'h55, 32'hDEADBEEF, 32'h0, 32'h7, 32'hDEADBEEF, 1'b0, 0));
    vq.push_back(mk(5'h11, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1));
    vq.push_back(mk(5'h10, 1'b0, 1'b0, 32'h12345678, 32'h10, 32'h0, 32'h0, 32'h23456780, 1'b0, 1));
    vq.push_back(mk(5'h13, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1));
    vq.push_back(mk(5'h12, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1));
    vq.push_back(mk(5'h14, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h80000000, 1'b0, 0));
    vq.push_back(mk(5'h16, 1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 1'b0, 0));
    vq.push_back(mk(5'h17, 1'b0, 1'b0, 32'd7, 32'd0, 32'h0, 32'h0, 32'h00000007, 1'b0, 0));
    vq.push_back(mk(5'h15, 1'b0, 1'b0, 32'd7, 32'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 0));
    vq.push_back(mk(5'h14, 1'b0, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 0));
    vq.push_back(mk(5'h14, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFD, 1'b0, 2));
    vq.push_back(mk(5'h16, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 2));
    vq.push_back(mk(5'h15, 1'b0, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0000000E, 1'b0, 2));
    vq.push_back(mk(5'h17, 1'b0, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 32'h00000002, 1'b0, 2));
    vq.push_back(mk(5'h14, 1'b0, 1'b0, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'hFFFFFFFD, 1'b0, 2));
    vq.push_back(mk(5'h16, 1'b0, 1'b0, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 1'b0, 2));
    vq.push_back(mk(5'h1F, 1'b0, 1'b0, 32'd9, 32'd9, 32'h0, 32'h0, 32'h00000000, 1'b1, 0));
    vq.push_back(mk(5'h0C, 1'b0, 1'b0, 32'd9, 32'd9, 32'h0, 32'h0, 32'h00000000, 1'b1, 0));

    for (int i = 0; i < vq.size(); i++) begin
      run_op(vq[i], $sformatf("vec%0d_op%02h", i, vq[i].op));
    end

    // Back-pressure: result held 5 cycles, a competing request is not accepted.
    wait_ready("bp");
    drive(mk(5'h14, 1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'h0, 1'b0, 2));
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", W'(lat), 32'd33);
    check("bp_result", result, 32'hFFFFFFFD);
    op = 5'h00; rdata1 = 32'd1; rdata2 = 32'd1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_hold%0d_result", c), result, 32'hFFFFFFFD);
      check($sformatf("bp_hold%0d_flags", c), {29'd0, in_ready, out_valid, busy}, 32'd3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);

    // Flush of an in-flight divide at cycle 10.
    wait_ready("fl");
    drive(mk(5'h15, 1'b0, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0, 1'b0, 2));
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_cycle11", {29'd0, in_ready, out_valid, busy}, 32'd4);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("fl_no_valid", W'(seen), 32'd0);

    // Flush together with in_valid in IDLE: nothing accepted.
    drive(mk(5'h00, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_idle_no_accept", {29'd0, in_ready, out_valid, busy}, 32'd4);

    // Flush in DONE without out_ready drops the result; flush with out_ready also returns to IDLE.
    drive(mk(5'h00, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    tick();
    in_valid = 1'b0;
    check("fl_done_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_done_drop", {29'd0, in_ready, out_valid, busy}, 32'd4);
    drive(mk(5'h00, 1'b0, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    check("fl_vs_ready", {29'd0, in_ready, out_valid, busy}, 32'd4);

    // Asynchronous reset mid-iteration.
    run_op(mk(5'h00, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h2, 1'b0, 0), "ar_pre");
    drive(mk(5'h13, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, 1));
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("ar_flags", {28'd0, in_ready, out_valid, illegal_op, busy}, 32'h8);
    check("ar_result", result, 32'h0);
    rst_n = 1'b1;
    tick();
    check("ar_after_idle", {28'd0, in_ready, out_valid, illegal_op, busy}, 32'h8);
    v = mk(5'h15, 1'b0, 1'b0, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0000000E, 1'b0, 2);
    run_op(v, "ar_post_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
